// File: rtl/ifetch_unit.sv
// Fetch engine: issues imem requests at pc_addr, buffers in-order responses as {pc, inst} for decode.
// Response at cycle N is visible to decode at N+1; requests stop while outstanding + dropping + buffered fills DEPTH.
module ifetch_unit #(
    parameter int ADDR_W = 64,
    parameter int INST_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_enable,
    input  logic              redirect,
    output logic              imem_req_valid,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_data,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [INST_W-1:0] inst_data,
    input  logic              inst_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = CW + 2;

    logic [CW-1:0]     outstanding_q, outstanding_d;
    logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     pcq_wr_q, pcq_rd_q, buf_wr_q, buf_rd_q;
    logic [ADDR_W-1:0] pcq_q     [DEPTH];
    logic [ADDR_W-1:0] buf_pc_q  [DEPTH];
    logic [INST_W-1:0] buf_dat_q [DEPTH];

    logic [SW-1:0] credit_sum;
    logic [CW:0]   inflight;
    logic          credit_ok, req_fire, resp_live, resp_drop, inst_pop;

    // Credit uses only registered occupancy so a same-cycle pop never opens a slot.
    assign credit_sum = SW'(outstanding_q) + SW'(drop_cnt_q) + SW'(count_q);
    assign credit_ok  = credit_sum < SW'(DEPTH);
    assign inflight   = (CW+1)'(outstanding_q) + (CW+1)'(drop_cnt_q);

    assign imem_req_valid = ~reset & fetch_en & ~redirect & credit_ok;
    assign imem_req_addr  = pc_addr;
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign pc_enable      = ~reset & (req_fire | redirect);

    assign resp_drop = imem_resp_valid & (drop_cnt_q != '0);
    assign resp_live = imem_resp_valid & (drop_cnt_q == '0) & (outstanding_q != '0);

    assign inst_valid = (count_q != '0);
    assign inst_pc    = buf_pc_q[buf_rd_q];
    assign inst_data  = buf_dat_q[buf_rd_q];
    assign inst_pop   = inst_valid & inst_ready;

    always_comb begin
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        count_d       = count_q;
        if (redirect) begin
            // Everything still in flight becomes a response to discard; one arriving now is already gone.
            outstanding_d = '0;
            count_d       = '0;
            if (imem_resp_valid && inflight != '0)
                drop_cnt_d = CW'(inflight - (CW+1)'(1));
            else
                drop_cnt_d = CW'(inflight);
        end else begin
            outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_live);
            count_d       = count_q + CW'(resp_live) - CW'(inst_pop);
            if (resp_drop)
                drop_cnt_d = drop_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            pcq_wr_q      <= '0;
            pcq_rd_q      <= '0;
            buf_wr_q      <= '0;
            buf_rd_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pcq_q[i]     <= '0;
                buf_pc_q[i]  <= '0;
                buf_dat_q[i] <= '0;
            end
        end else begin
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            if (redirect) begin
                pcq_wr_q <= '0;
                pcq_rd_q <= '0;
                buf_wr_q <= '0;
                buf_rd_q <= '0;
            end else begin
                if (req_fire) begin
                    pcq_q[pcq_wr_q] <= pc_addr;
                    pcq_wr_q        <= pcq_wr_q + PW'(1);
                end
                if (resp_live) begin
                    buf_pc_q[buf_wr_q]  <= pcq_q[pcq_rd_q];
                    buf_dat_q[buf_wr_q] <= imem_resp_data;
                    pcq_rd_q            <= pcq_rd_q + PW'(1);
                    buf_wr_q            <= buf_wr_q + PW'(1);
                end
                if (inst_pop)
                    buf_rd_q <= buf_rd_q + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: owns the PC and a fixed-latency in-order memory, and checks the DUT every cycle
// against a queue model of in-flight and decoded instructions, plus literal expectations per scenario.
module tb_ifetch_unit;

    localparam int DEPTH = 2;

    logic        clk;
    logic        reset, fetch_en, redirect, imem_req_ready, imem_resp_valid, inst_ready;
    logic [63:0] pc_addr;
    logic        pc_enable, imem_req_valid, inst_valid;
    logic [63:0] imem_req_addr, inst_pc;
    logic [31:0] imem_resp_data, inst_data;

    ifetch_unit #(.ADDR_W(64), .INST_W(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en), .pc_addr(pc_addr), .pc_enable(pc_enable),
        .redirect(redirect), .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .inst_valid(inst_valid), .inst_pc(inst_pc),
        .inst_data(inst_data), .inst_ready(inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [63:0] addr; int due; bit live; } mreq_t;
    typedef struct { logic [63:0] pc; logic [31:0] dat; } ent_t;

    mreq_t       mem[$];
    ent_t        bq[$];
    logic [63:0] dec_pc[$];
    logic [31:0] dec_dat[$];

    int          checks = 0, errors = 0, cyc = 0, lat = 1, late_drop = 0;
    bit          rst = 1, fe = 0, rr = 1, ir = 1, rd = 0, resp_v = 0, exp_rv;
    logic [63:0] pc = 0, tgt = 0, rst_pc = 0;

    // addi x(i&31), x0, i for word i: pcs 0,4,8 give 0x00000013, 0x00100093, 0x00200113
    function automatic logic [31:0] mdata(input logic [63:0] a);
        logic [63:0] i;
        i = a >> 2;
        return {i[11:0], 8'h00, i[4:0], 7'h13};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick_a();
        @(negedge clk);
        resp_v          = !rst && mem.size() > 0 && mem[0].due <= cyc;
        reset           = rst;
        fetch_en        = fe;
        redirect        = rd;
        imem_req_ready  = rr;
        inst_ready      = ir;
        pc_addr         = pc;
        imem_resp_valid = resp_v;
        imem_resp_data  = resp_v ? mdata(mem[0].addr) : 32'($urandom());
        #1;
        if (!rst) begin
            exp_rv = fe && !rd && (mem.size() + bq.size() < DEPTH);
            chk("req_valid", imem_req_valid, exp_rv);
            chk("req_addr", imem_req_addr, pc);
            chk("pc_enable", pc_enable, (exp_rv && rr) || rd);
            chk("inst_valid", inst_valid, bq.size() != 0);
            if (bq.size() != 0) begin
                chk("inst_pc", inst_pc, bq[0].pc);
                chk("inst_data", inst_data, bq[0].dat);
            end
        end
    endtask

    task automatic tick_b();
        mreq_t e;
        bit fire, pop;
        if (rst) begin
            mem.delete();
            bq.delete();
            pc = rst_pc;
            late_drop = 0;
        end else begin
            fire = imem_req_valid && rr;
            pop  = inst_valid && ir;
            if (pop) begin
                dec_pc.push_back(inst_pc);
                dec_dat.push_back(inst_data);
            end
            if (rd) begin
                if (resp_v) e = mem.pop_front();
                foreach (mem[i]) mem[i].live = 1'b0;
                bq.delete();
                pc = tgt;
            end else begin
                if (pop && bq.size() != 0) void'(bq.pop_front());
                if (resp_v) begin
                    e = mem.pop_front();
                    if (e.live) bq.push_back('{e.addr, mdata(e.addr)});
                    else late_drop++;
                end
                if (fire) begin
                    mem.push_back('{pc, cyc + lat, 1'b1});
                    pc = pc + 64'd4;
                end
            end
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic cycle();
        tick_a();
        tick_b();
    endtask

    task automatic do_reset(input logic [63:0] pc0);
        rst = 1; rd = 0; rst_pc = pc0;
        cycle();
        cycle();
        rst = 0;
        dec_pc.delete();
        dec_dat.delete();
    endtask

    task automatic wait_dec(input int n);
        for (int i = 0; i < 200; i++) begin
            if (dec_pc.size() >= n) break;
            cycle();
        end
        chk("wait_dec_timeout", dec_pc.size() >= n, 1);
    endtask

    task automatic drain();
        fe = 0; ir = 1; rr = 1;
        for (int i = 0; i < 100; i++) begin
            if (mem.size() == 0 && bq.size() == 0) break;
            cycle();
        end
        chk("drain_timeout", mem.size() == 0 && bq.size() == 0, 1);
    endtask

    initial begin
        reset = 1; fetch_en = 0; redirect = 0; imem_req_ready = 1; imem_resp_valid = 0;
        imem_resp_data = 0; inst_ready = 1; pc_addr = 0;

        // Stream
        lat = 1; ir = 1; rr = 1;
        do_reset(64'h0);
        tick_a();
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_inst_data", inst_data, 0);
        tick_b();
        fe = 1;
        wait_dec(3);
        drain();
        chk("stream_pc0", dec_pc[0], 64'h0);
        chk("stream_pc1", dec_pc[1], 64'h4);
        chk("stream_pc2", dec_pc[2], 64'h8);
        chk("stream_d0", dec_dat[0], 32'h00000013);
        chk("stream_d1", dec_dat[1], 32'h00100093);
        chk("stream_d2", dec_dat[2], 32'h00200113);

        // Decode backpressure
        do_reset(64'h0);
        fe = 1; ir = 0;
        repeat (5) cycle();
        tick_a();
        chk("bp_req_valid", imem_req_valid, 0);
        chk("bp_pc_enable", pc_enable, 0);
        chk("bp_pc_addr", pc_addr, 64'h8);
        chk("bp_head_valid", inst_valid, 1);
        chk("bp_head_pc", inst_pc, 64'h0);
        tick_b();
        ir = 1;
        wait_dec(3);
        drain();
        chk("bp_pc0", dec_pc[0], 64'h0);
        chk("bp_pc1", dec_pc[1], 64'h4);
        chk("bp_pc2", dec_pc[2], 64'h8);

        // Memory stall
        do_reset(64'h10);
        fe = 1; rr = 0;
        repeat (3) begin
            tick_a();
            chk("stall_req_valid", imem_req_valid, 1);
            chk("stall_req_addr", imem_req_addr, 64'h10);
            chk("stall_pc_enable", pc_enable, 0);
            tick_b();
        end
        rr = 1;
        tick_a();
        chk("stall_accept", pc_enable, 1);
        tick_b();
        fe = 0;
        tick_a();
        chk("stall_pc_next", pc_addr, 64'h14);
        tick_b();
        drain();
        chk("stall_dec_pc", dec_pc[0], 64'h10);

        // Redirect with two requests in flight
        lat = 3;
        do_reset(64'h20);
        fe = 1;
        cycle();
        cycle();
        rd = 1; tgt = 64'h100;
        tick_a();
        chk("redir_inflight", mem.size(), 2);
        chk("redir_pc_enable", pc_enable, 1);
        chk("redir_req_valid", imem_req_valid, 0);
        tick_b();
        rd = 0;
        wait_dec(1);
        drain();
        chk("redir_first_pc", dec_pc[0], 64'h100);
        chk("redir_drops", late_drop, 2);

        // Redirect coinciding with a response
        lat = 2;
        do_reset(64'h40);
        fe = 1;
        cycle();
        cycle();
        rd = 1; tgt = 64'h200;
        tick_a();
        chk("redir_resp_coincide", imem_resp_valid, 1);
        tick_b();
        rd = 0;
        repeat (8) cycle();
        drain();
        chk("coinc_drops", late_drop, 1);
        chk("coinc_first_pc", dec_pc[0], 64'h200);
        begin
            int stale = 0;
            foreach (dec_pc[i]) if (dec_pc[i] < 64'h200) stale++;
            chk("coinc_stale_decoded", stale, 0);
        end

        // Reset with a full buffer
        lat = 1;
        do_reset(64'h0);
        fe = 1; ir = 0;
        repeat (4) cycle();
        tick_a();
        chk("full_inst_valid", inst_valid, 1);
        chk("full_credit", imem_req_valid, 0);
        tick_b();
        rst = 1; rst_pc = 64'h300;
        cycle();
        rst = 0; fe = 0;
        dec_pc.delete();
        dec_dat.delete();
        tick_a();
        chk("mrst_inst_valid", inst_valid, 0);
        chk("mrst_req_valid", imem_req_valid, 0);
        chk("mrst_pc_enable", pc_enable, 0);
        chk("mrst_inst_pc", inst_pc, 0);
        chk("mrst_inst_data", inst_data, 0);
        tick_b();
        fe = 1; ir = 1;
        wait_dec(2);
        drain();
        chk("mrst_first_pc", dec_pc[0], 64'h300);
        chk("mrst_second_pc", dec_pc[1], 64'h304);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Consumer side of the program counter: takes the current fetch address, issues instruction-memory requests, and collects in-order responses. Delivers {pc, instruction} pairs to decode over a valid/ready handshake.
- Owns the PC advance strobe (`pc_enable`).
- On redirect (branch, trap or debug), flushes all in-flight and buffered instructions so only the new stream reaches decode.

Parameters:
- ADDR_W, 64, fetch address width (matches PC width).
- INST_W, 32, instruction word width.
- DEPTH, 2, instruction buffer entries. Also the maximum combined count of outstanding requests plus buffered instructions. Power of two, ≥2.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- fetch_en  input  1  1 = fetching allowed. 0 = issue no new requests; in-flight requests still complete.
- pc_addr  input  ADDR_W  current PC value
- pc_enable  output  1  PC advance/load strobe, combinational
- redirect  input  1  PC is being redirected this cycle; external logic drives the PC select to a non-sequential source
- imem_req_valid  output  1  request valid
- imem_req_addr  output  ADDR_W  request address, equal to pc_addr
- imem_req_ready  input  1  memory accepts the request
- imem_resp_valid  input  1  response data valid, in request order, no backpressure
- imem_resp_data  input  INST_W  instruction word
- inst_valid  output  1  decode-side valid
- inst_pc  output  ADDR_W  PC of the presented instruction
- inst_data  output  INST_W  presented instruction
- inst_ready  input  1  decode accepts the instruction

Behaviour:
- State:
  - `outstanding`: counter 0..DEPTH of accepted requests still awaiting a response.
  - `drop_cnt`: counter 0..DEPTH of responses to discard.
  - Request PC queue: DEPTH entries holding the address of each outstanding live request.
  - Instruction buffer: DEPTH-entry FIFO of {pc, data}.
  - `count`: buffer occupancy.
- Credit: `credit_ok` = (outstanding + drop_cnt + count < DEPTH). Use registered values only; a same-cycle pop does not grant credit.
- Request issue:
  - imem_req_valid = fetch_en & ~redirect & credit_ok.
  - imem_req_addr = pc_addr.
  - Handshake on imem_req_valid & imem_req_ready: push pc_addr onto the PC queue and increment `outstanding`.
- PC advance: pc_enable = (imem_req_valid & imem_req_ready) | redirect.
  - The PC increments by 4 the cycle after each accepted request.
  - The PC loads the redirect target the cycle after a redirect.
  - pc_addr is therefore stable while a request is pending unaccepted.
- Response, when drop_cnt > 0: discard it and decrement drop_cnt.
- Response, when drop_cnt = 0:
  - Pop the PC queue.
  - Push {popped pc, imem_resp_data} into the buffer.
  - Decrement `outstanding`.
  - Credit guarantees the buffer is never full at push.
- Response with `outstanding` = 0 and drop_cnt = 0 is a protocol violation. Ignore it: no state change.
- Decode side:
  - inst_valid = (count ≠ 0).
  - inst_pc and inst_data come from the buffer head.
  - Pop on inst_valid & inst_ready.
  - Head fields hold stable while inst_valid & ~inst_ready.
  - Push and pop in the same cycle leave `count` unchanged.
  - Latency: response at cycle N → inst_valid at N+1.
- Redirect cycle:
  - Clear the buffer (count = 0, pointers to 0) and clear the PC queue.
  - Set outstanding = 0.
  - drop_cnt ← outstanding + drop_cnt − (imem_resp_valid ? 1 : 0). A response in the redirect cycle is discarded.
  - Issue no request.
  - inst_valid drops to 0 the next cycle; a decode pop in the redirect cycle is still honoured.
- fetch_en = 0: no new requests; responses still buffered; pc_enable is only from redirect.
- Reset (synchronous, dominates redirect):
  - All counters and pointers go to 0.
  - inst_valid = 0, imem_req_valid = 0, pc_enable = 0.
  - inst_pc = 0, inst_data = 0.
  - Memory must also be reset; responses arriving after reset are treated per the protocol-violation rule above.
- Counter widths: $clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.

Test Plan:
- Stream: reset, then fetch_en = 1, pc starting at 0x0, ready always 1, 1-cycle memory, inst_ready = 1.
  - Required: pc_enable on each accept.
  - Required: decode sees pcs 0x0, 0x4, 0x8 with data 0x00000013, 0x00100093, 0x00200113, in order.
- Backpressure: inst_ready = 0 with DEPTH = 2.
  - Required: after 2 accepted requests, imem_req_valid = 0 and pc_enable = 0, pc_addr stays 0x8, and the head stays pc 0x0 stable.
  - Required: raising inst_ready resumes fetch with no loss or duplication.
- Memory stall: imem_req_ready = 0 for 3 cycles.
  - Required: imem_req_valid stays 1, imem_req_addr stays 0x10, pc_enable = 0.
  - Required: accept on the 4th cycle, then pc_addr becomes 0x14.
- Redirect with 2 outstanding: assert redirect while the 0x20 and 0x24 requests are in flight; PC target 0x100.
  - Required: both stale responses are dropped (drop_cnt 2→0).
  - Required: the first decoded instruction is pc 0x100.
- Redirect coinciding with a response: drop_cnt = 1 after the redirect, and only the new-target instruction reaches decode.
- Reset mid-stream with a full buffer: the next cycle shows inst_valid = 0, imem_req_valid = 0, pc_enable = 0, and all counters 0.
